// File: rtl/btn_evt_pkg.sv
// Shared constants and types for the button event arbiter.
package btn_evt_pkg;
    localparam int unsigned N_BTN_DEF     = 5;
    localparam logic [31:0] REP_DELAY_DEF = 32'd50_000_000;
    localparam logic [31:0] REP_RATE_DEF  = 32'd10_000_000;
    localparam int unsigned BTN_ID_W      = 3;

    typedef logic [N_BTN_DEF-1:0] btn_vec_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from last+1, wrapping.
module rr_arbiter #(
    parameter int unsigned N    = 5,
    parameter int unsigned ID_W = 3
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        return (s >= N) ? s - N : s;
    endfunction

    // Scan from farthest to nearest so the nearest requester after last is the final write.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int unsigned k = N; k >= 1; k--) begin
            if (req[IDX_W'(wrap_idx(32'(last), k))]) begin
                gnt_idx = ID_W'(wrap_idx(32'(last), k));
                any     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/btn_event_arbiter.sv
// Turns button presses (and optional auto-repeats) into a round-robin ready/valid event stream.
// Auto-repeat is compiled in when BTN_AUTOREPEAT_EN is defined.
module btn_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN     = N_BTN_DEF,
    parameter logic [31:0] REP_DELAY = REP_DELAY_DEF,
    parameter logic [31:0] REP_RATE  = REP_RATE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_BTN-1:0]    btn_in,
    input  logic                ev_ready,
    input  logic                clr_ovf,
    output logic                ev_valid,
    output logic [BTN_ID_W-1:0] ev_id,
    output logic                ev_repeat,
    output logic [N_BTN-1:0]    pending,
    output logic                ovf
);
    logic [N_BTN-1:0]    prev, press, rep_evt, ev_new, pend_clr, pend_nxt;
    logic [BTN_ID_W-1:0] last_grant, gnt_idx;
    logic                gnt_any, load, ovf_nxt;

    rr_arbiter #(.N(N_BTN), .ID_W(BTN_ID_W)) u_rr (
        .req     (pending),
        .last    (last_grant),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // A new event on a bit being granted this cycle re-queues it; only a still-pending bit overflows.
    always_comb begin
        load     = !ev_valid || ev_ready;
        press    = btn_in & ~prev;
        ev_new   = press | rep_evt;
        pend_clr = pending;
        if (load && gnt_any) begin
            pend_clr[gnt_idx] = 1'b0;
        end
        pend_nxt = pend_clr | ev_new;
        ovf_nxt  = ovf;
        if (clr_ovf) begin
            ovf_nxt = 1'b0;
        end
        if (|(ev_new & pend_clr)) begin
            ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '1;
            pending    <= '0;
            ovf        <= 1'b0;
            ev_valid   <= 1'b0;
            ev_id      <= '0;
            last_grant <= BTN_ID_W'(N_BTN - 1);
        end else begin
            prev    <= btn_in;
            pending <= pend_nxt;
            ovf     <= ovf_nxt;
            if (load) begin
                ev_valid <= gnt_any;
                if (gnt_any) begin
                    ev_id      <= gnt_idx;
                    last_grant <= gnt_idx;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [31:0]      hold_cnt;
    logic [N_BTN-1:0] rep_flag;
    logic             held, rep_fire;

    // The hold counter only runs while a non-zero button pattern is unchanged.
    always_comb begin
        held     = (btn_in == prev) && (|btn_in);
        rep_fire = held && (hold_cnt == REP_DELAY - 32'd1);
        rep_evt  = rep_fire ? btn_in : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            rep_flag  <= '0;
            ev_repeat <= 1'b0;
        end else begin
            if (!held) begin
                hold_cnt <= '0;
            end else if (rep_fire) begin
                hold_cnt <= REP_DELAY - REP_RATE;
            end else begin
                hold_cnt <= hold_cnt + 32'd1;
            end
            rep_flag <= (rep_flag & ~ev_new) | rep_evt;
            if (load && gnt_any) begin
                ev_repeat <= rep_flag[gnt_idx];
            end
        end
    end
`else
    logic unused_rep_params;
    assign unused_rep_params = ^{REP_DELAY, REP_RATE};
    assign rep_evt           = '0;
    assign ev_repeat         = 1'b0;
`endif
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Self-checking bench for btn_event_arbiter; the auto-repeat scenario runs when BTN_AUTOREPEAT_EN is defined.
module tb_btn_event_arbiter;
    import btn_evt_pkg::*;

    typedef struct packed {
        logic [BTN_ID_W-1:0] id;
        logic                rep;
    } exp_t;

    logic                clk;
    logic                rst_n;
    btn_vec_t            btn_in;
    logic                ev_ready;
    logic                clr_ovf;
    logic                ev_valid;
    logic [BTN_ID_W-1:0] ev_id;
    logic                ev_repeat;
    btn_vec_t            pending;
    logic                ovf;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t mon_exp;

    btn_event_arbiter #(.N_BTN(N_BTN_DEF), .REP_DELAY(32'd8), .REP_RATE(32'd4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .ev_ready  (ev_ready),
        .clr_ovf   (clr_ovf),
        .ev_valid  (ev_valid),
        .ev_id     (ev_id),
        .ev_repeat (ev_repeat),
        .pending   (pending),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every accepted handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got id=%0d rep=%0d, required none", ev_id, ev_repeat);
            end else begin
                mon_exp = sb.pop_front();
                if (ev_id !== mon_exp.id || ev_repeat !== mon_exp.rep) begin
                    miscompares++;
                    $display("FAIL event: got id=%0d rep=%0d, required id=%0d rep=%0d",
                             ev_id, ev_repeat, mon_exp.id, mon_exp.rep);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick;
        rst_n = 1'b0; btn_in = '0; ev_ready = 1'b0; clr_ovf = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; btn_in = 5'b00001; ev_ready = 1'b1; clr_ovf = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ev_valid, ev_id, ev_repeat, pending, ovf} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b id=%0d rep=%b pend=%b ovf=%b, required all 0",
                     ev_valid, ev_id, ev_repeat, pending, ovf);
        end
        tick;
        rst_n = 1'b1;
        repeat (10) tick;
        @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b0 || pending !== 5'b0) begin
            miscompares++;
            $display("FAIL held_through_reset: got v=%b pend=%b, required v=0 pend=00000", ev_valid, pending);
        end
        tick;
        btn_in = '0;
        repeat (2) tick;
    endtask

    task automatic test_press_latency;
        tick;
        btn_in = 5'b00100;
        sb.push_back(exp_t'{3'd2, 1'b0});
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (pending !== 5'b00100 || ev_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL press_detect: got pend=%b v=%b, required pend=00100 v=0", pending, ev_valid);
        end
        @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b1 || ev_id !== 3'd2 || ev_repeat !== 1'b0 || pending !== 5'b0) begin
            miscompares++;
            $display("FAIL press_present: got v=%b id=%0d rep=%b pend=%b, required v=1 id=2 rep=0 pend=00000",
                     ev_valid, ev_id, ev_repeat, pending);
        end
        @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL press_drop: got v=%b, required v=0", ev_valid);
        end
        tick;
        btn_in = '0;
        repeat (2) tick;
    endtask

    task automatic test_round_robin;
        logic [BTN_ID_W-1:0] ids [3];
        ids = '{3'd0, 3'd1, 3'd4};
        do_reset;
        tick;
        ev_ready = 1'b1;
        btn_in   = 5'b10011;
        for (int k = 0; k < 3; k++) sb.push_back(exp_t'{ids[k], 1'b0});
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (pending !== 5'b10011) begin
            miscompares++;
            $display("FAIL rr_pending: got %b, required 10011", pending);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (ev_valid !== 1'b1 || ev_id !== ids[k]) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got v=%b id=%0d, required v=1 id=%0d", k, ev_valid, ev_id, ids[k]);
            end
        end
        @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b0 || pending !== 5'b0) begin
            miscompares++;
            $display("FAIL rr_drain: got v=%b pend=%b, required v=0 pend=00000", ev_valid, pending);
        end
        tick;
        btn_in = '0;
        repeat (2) tick;
    endtask

    // Pass 1 raises clr_ovf in the same cycle as the overflow: set must win.
    task automatic test_overflow;
        for (int pass = 0; pass < 2; pass++) begin
            tick; ev_ready = 1'b0; btn_in = 5'b00001;
            tick; btn_in = '0;
            tick; btn_in = 5'b01000;
            tick; btn_in = '0;
            tick; btn_in = 5'b01000; clr_ovf = (pass == 1);
            tick; btn_in = '0; clr_ovf = 1'b0; ev_ready = 1'b1;
            sb.push_back(exp_t'{3'd0, 1'b0});
            sb.push_back(exp_t'{3'd3, 1'b0});
            @(negedge clk);
            vectors++;
            if (ovf !== 1'b1 || pending !== 5'b01000 || ev_valid !== 1'b1 || ev_id !== 3'd0) begin
                miscompares++;
                $display("FAIL ovf_set[%0d]: got ovf=%b pend=%b v=%b id=%0d, required ovf=1 pend=01000 v=1 id=0",
                         pass, ovf, pending, ev_valid, ev_id);
            end
            @(negedge clk);
            vectors++;
            if (ev_valid !== 1'b1 || ev_id !== 3'd3) begin
                miscompares++;
                $display("FAIL ovf_event[%0d]: got v=%b id=%0d, required v=1 id=3", pass, ev_valid, ev_id);
            end
            @(negedge clk);
            vectors++;
            if (ev_valid !== 1'b0 || pending !== 5'b0) begin
                miscompares++;
                $display("FAIL ovf_single[%0d]: got v=%b pend=%b, required v=0 pend=00000", pass, ev_valid, pending);
            end
            tick; clr_ovf = 1'b1;
            tick; clr_ovf = 1'b0;
            @(negedge clk);
            vectors++;
            if (ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL ovf_clear[%0d]: got ovf=%b, required 0", pass, ovf);
            end
        end
    endtask

    task automatic test_midop_reset;
        tick; ev_ready = 1'b0; btn_in = 5'b00001;
        tick; btn_in = '0;
        tick; btn_in = 5'b01000;
        tick;
        @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b1 || pending !== 5'b01000) begin
            miscompares++;
            $display("FAIL midop_setup: got v=%b pend=%b, required v=1 pend=01000", ev_valid, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ev_valid, ev_id, ev_repeat, pending, ovf} !== 11'b0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b id=%0d rep=%b pend=%b ovf=%b, required all 0",
                     ev_valid, ev_id, ev_repeat, pending, ovf);
        end
        tick; ev_ready = 1'b1;
        tick; rst_n = 1'b1;
        repeat (10) tick;
        @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b0 || pending !== 5'b0) begin
            miscompares++;
            $display("FAIL after_reset: got v=%b pend=%b, required v=0 pend=00000", ev_valid, pending);
        end
        tick;
        btn_in = '0;
        repeat (2) tick;
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat;
        logic exp_v;
        do_reset;
        tick;
        ev_ready = 1'b1;
        btn_in   = 5'b00010;
        sb.push_back(exp_t'{3'd1, 1'b0});
        repeat (3) sb.push_back(exp_t'{3'd1, 1'b1});
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk);
            #1;
            if (c == 20) btn_in = '0;
            @(negedge clk);
            exp_v = (c == 2) || (c == 10) || (c == 14) || (c == 18);
            vectors++;
            if (ev_valid !== exp_v || (exp_v && ev_repeat !== (c != 2))) begin
                miscompares++;
                $display("FAIL autorepeat[c%0d]: got v=%b rep=%b, required v=%b rep=%b",
                         c, ev_valid, ev_repeat, exp_v, (c != 2));
            end
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; btn_in = '0; ev_ready = 1'b0; clr_ovf = 1'b0;
        test_reset;
        test_press_latency;
        test_round_robin;
        test_overflow;
        test_midop_reset;
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat;
`endif
        repeat (4) tick;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 SHALL have parameter N_BTN, default 5: number of button inputs.
REQ-002 SHALL have parameter REP_DELAY, default 32'd50_000_000: hold cycles before the first auto-repeat.
REQ-003 SHALL have parameter REP_RATE, default 32'd10_000_000: cycles between later auto-repeats; legal range 1..REP_DELAY.
REQ-004 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port btn_in, input, N_BTN: debounced button levels, synchronous to clk.
REQ-007 SHALL have port ev_ready, input, 1: consumer accepts the presented event.
REQ-008 SHALL have port clr_ovf, input, 1: synchronous clear of ovf.
REQ-009 SHALL have port ev_valid, output, 1: an event is presented.
REQ-010 SHALL have port ev_id, output, 3: index of the button for the presented event.
REQ-011 SHALL have port ev_repeat, output, 1: the presented event is an auto-repeat, not a press.
REQ-012 SHALL have port pending, output, N_BTN: events that are queued and not yet presented.
REQ-013 SHALL have port ovf, output, 1: sticky flag; an event was lost.

Function
REQ-014 SHALL register btn_in into prev each cycle; a press on bit i is btn_in[i]=1 while prev[i]=0.
REQ-015 SHALL set pending[i] on the same clock edge that detects the press, with rep_flag[i]=0.
REQ-016 SHALL load the output register when ev_valid=0, or when ev_valid=1 and ev_ready=1 in that cycle.
REQ-017 SHALL, at each load:
- select the round-robin winner among pending bits, searching upward from last_grant+1 with wrap at N_BTN-1 to 0;
- drive ev_id and ev_repeat from the winner;
- assert ev_valid;
- clear the winner's pending bit;
- update last_grant.
REQ-018 SHALL deassert ev_valid at a load when no pending bit is set.
REQ-019 SHALL hold ev_id and ev_repeat stable while ev_valid=1 and ev_ready=0.
REQ-020 SHALL present an event at latency 1: press detected at edge t gives ev_valid=1 after edge t+1, if the output register is free.
REQ-021 SHALL keep pending[i] set when a new event on i arrives in the same cycle that i is granted; the new event stays queued.
REQ-022 SHALL set ovf when an event arrives on i while pending[i] is already 1; pending[i] stays 1 and rep_flag[i] takes the new event's type.
REQ-023 SHALL handle clr_ovf and a new overflow in the same cycle with ovf=1 (set wins).
REQ-024 SHALL let ev_ready have no effect while ev_valid=0.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously set:
- ev_valid=0, ev_id=0, ev_repeat=0, pending=0, ovf=0;
- rep_flag=0, last_grant=N_BTN-1, hold counter=0;
- prev all-ones, so buttons held through reset produce no press.
REQ-026 SHALL discard any in-flight or queued event when reset is asserted mid-operation.
REQ-027 SHALL sample the first press no earlier than the first edge after rst_n rises.

Configuration
REQ-028 SHALL compile in auto-repeat when BTN_AUTOREPEAT_EN is defined.
- hold_cnt (32-bit) resets to 0 when btn_in changes or btn_in=0; otherwise it increments.
- When hold_cnt reaches REP_DELAY-1, set pending[i] and rep_flag[i]=1 for every held i, then load hold_cnt with REP_DELAY-REP_RATE.
REQ-029 SHALL, without BTN_AUTOREPEAT_EN, contain no hold counter, tie ev_repeat to 0 and ignore REP_DELAY and REP_RATE.

Structure
REQ-030 SHALL place in shared package btn_evt_pkg:
- N_BTN, REP_DELAY and REP_RATE default constants;
- BTN_ID_W=3;
- typedef btn_vec_t.
REQ-031 SHALL implement the round-robin pick as sub-module rr_arbiter, which is combinational with inputs req and last and outputs gnt_idx and any.

Verification
REQ-032 SHALL cover: reset, hold btn_in=5'b00001, release rst_n -> no event ever.
REQ-033 SHALL cover: btn_in 0 -> 5'b00100, ev_ready=1 -> ev_valid=1 one cycle after detection, ev_id=2, ev_repeat=0, pending=0.
REQ-034 SHALL cover: 5'b10011 pressed at once, ev_ready=1, last_grant=4 -> ev_id sequence 0, 1, 4 on consecutive cycles.
REQ-035 SHALL cover: ev_ready=0, press button 3, release, press button 3 again -> ovf=1; one event for id 3 after ev_ready rises; clr_ovf -> ovf=0.
REQ-036 SHALL cover: with BTN_AUTOREPEAT_EN, REP_DELAY=8, REP_RATE=4, hold 5'b00010 for 20 cycles -> one press event, then repeat events (ev_repeat=1, id 1) at hold_cnt=7 and every 4 cycles after.
REQ-037 SHALL cover: rst_n low while ev_valid=1 and pending=5'b01000 -> all outputs 0 immediately, no event after release.
